mem_cmd_engine: RTL

MEM_CMD_ENGINE -- requirements
Module: mem_cmd_engine

---
 rtl/mem_cmd_engine.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_cmd_engine.sv
// -----------------------------------------------------------------------------
// mem_cmd_engine
//   Byte-stream command engine in front of an internal word memory. Command
//   packets are popped from an rx byte FIFO, decoded, and executed against a
//   MEM_DEPTH x MEM_WIDTH memory. Read data is echoed into a tx byte FIFO, MSB
//   first.
//
//   Commands (multi-byte fields MSB first):
//     0x30 read         : cmd, addr
//     0x31 write        : cmd, addr, data
//     0x32 masked write : cmd, addr, data, mask (bit i enables byte i)
//     0x33 burst read   : cmd, addr, len (0 = no response, address wraps)
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   rx_fifo_empty   rx FIFO has no byte
//   rx_fifo_rd_en   pop one rx byte; it appears on din the following cycle
//   din             rx byte
//   tx_fifo_full    tx FIFO cannot accept a byte
//   tx_fifo_wr_en   push dout into the tx FIFO this cycle
//   dout            tx byte, zero when not pushing
//   cmd_err         one-cycle pulse after an unknown command byte
//   state_leds      [3:0] state code, [4] sticky error flag, [5] busy
// -----------------------------------------------------------------------------
module mem_cmd_engine #(
  parameter int FIFO_WIDTH = 8,
  parameter int MEM_WIDTH  = 32,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_fifo_empty,
  output logic                  rx_fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] din,
  input  logic                  tx_fifo_full,
  output logic                  tx_fifo_wr_en,
  output logic [FIFO_WIDTH-1:0] dout,
  output logic                  cmd_err,
  output logic [5:0]            state_leds
);

  localparam int NB = MEM_WIDTH / 8;
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int AB = (((AW + 7) / 8) < 1) ? 1 : ((AW + 7) / 8);

  localparam logic [7:0] AB_LAST = 8'(AB - 1);
  localparam logic [7:0] NB_LAST = 8'(NB - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(MEM_DEPTH - 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_GET_ADDR = 4'd1;
  localparam logic [3:0] S_GET_LEN  = 4'd2;
  localparam logic [3:0] S_GET_DATA = 4'd3;
  localparam logic [3:0] S_GET_MASK = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_RD_WAIT  = 4'd6;
  localparam logic [3:0] S_ECHO     = 4'd7;
  localparam logic [3:0] S_MEM_WR   = 4'd8;

  localparam logic [7:0] CMD_RD   = 8'h30;
  localparam logic [7:0] CMD_WR   = 8'h31;
  localparam logic [7:0] CMD_MWR  = 8'h32;
  localparam logic [7:0] CMD_BRD  = 8'h33;

  logic [3:0]           state_r;
  logic                 rd_pend_r;
  logic [7:0]           byte_cnt_r;
  logic [7:0]           cmd_r;
  logic [AW-1:0]        addr_r;
  logic [7:0]           len_r;
  logic [MEM_WIDTH-1:0] data_r;
  logic [NB-1:0]        mask_r;
  logic [MEM_WIDTH-1:0] shift_r;
  logic                 err_r;
  logic                 cmd_err_r;
  logic [MEM_WIDTH-1:0] mem_rd_data_r;
  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

  logic                 fetch_s;
  logic                 rd_en_s;
  logic                 wr_en_s;
  logic [AW-1:0]        addr_inc_s;

  // Handshake decode: pop only in byte-fetch states with no pop outstanding,
  // push only while echoing and the tx FIFO has room.
  always_comb begin
    fetch_s = 1'b0;
    case (state_r)
      S_IDLE, S_GET_ADDR, S_GET_LEN, S_GET_DATA, S_GET_MASK: fetch_s = 1'b1;
      default:                                               fetch_s = 1'b0;
    endcase
    rd_en_s = fetch_s && !rx_fifo_empty && !rd_pend_r;
    wr_en_s = (state_r == S_ECHO) && !tx_fifo_full;
  end

  // Next burst address, wrapping at the last memory word.
  always_comb begin
    if (addr_r == ADDR_LAST) begin
      addr_inc_s = '0;
    end else begin
      addr_inc_s = addr_r + AW'(1);
    end
  end

  // Outgoing byte is the top byte of the shift register, forced to zero when idle.
  always_comb begin
    if (wr_en_s) begin
      dout = shift_r[MEM_WIDTH-1 -: 8];
    end else begin
      dout = '0;
    end
  end

  assign rx_fifo_rd_en = rd_en_s;
  assign tx_fifo_wr_en = wr_en_s;
  assign cmd_err       = cmd_err_r;
  assign state_leds    = {(state_r != S_IDLE), err_r, state_r};

  // Command FSM: byte capture, field assembly, read echo sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      rd_pend_r  <= 1'b0;
      byte_cnt_r <= 8'd0;
      cmd_r      <= 8'd0;
      addr_r     <= '0;
      len_r      <= 8'd0;
      data_r     <= '0;
      mask_r     <= '0;
      shift_r    <= '0;
      err_r      <= 1'b0;
      cmd_err_r  <= 1'b0;
    end else begin
      cmd_err_r <= 1'b0;
      rd_pend_r <= rd_en_s;
      case (state_r)
        S_IDLE: begin
          if (rd_pend_r) begin
            cmd_r <= din;
            if (din inside {CMD_RD, CMD_WR, CMD_MWR, CMD_BRD}) begin
              byte_cnt_r <= 8'd0;
              state_r    <= S_GET_ADDR;
            end else begin
              cmd_err_r <= 1'b1;
              err_r     <= 1'b1;
            end
          end
        end
        S_GET_ADDR: begin
          if (rd_pend_r) begin
            // Keeping only the low AW bits drops address bits above AW.
            addr_r <= AW'({addr_r, din});
            if (byte_cnt_r == AB_LAST) begin
              byte_cnt_r <= 8'd0;
              case (cmd_r)
                CMD_WR, CMD_MWR: state_r <= S_GET_DATA;
                CMD_BRD:         state_r <= S_GET_LEN;
                default: begin
                  len_r   <= 8'd1;
                  state_r <= S_MEM_RD;
                end
              endcase
            end else begin
              byte_cnt_r <= byte_cnt_r + 8'd1;
            end
          end
        end
        S_GET_LEN: begin
          if (rd_pend_r) begin
            len_r      <= din;
            byte_cnt_r <= 8'd0;
            if (din == 8'd0) begin
              state_r <= S_IDLE;
            end else begin
              state_r <= S_MEM_RD;
            end
          end
        end
        S_GET_DATA: begin
          if (rd_pend_r) begin
            data_r <= MEM_WIDTH'({data_r, din});
            if (byte_cnt_r == NB_LAST) begin
              byte_cnt_r <= 8'd0;
              if (cmd_r == CMD_MWR) begin
                state_r <= S_GET_MASK;
              end else begin
                mask_r  <= '1;
                state_r <= S_MEM_WR;
              end
            end else begin
              byte_cnt_r <= byte_cnt_r + 8'd1;
            end
          end
        end
        S_GET_MASK: begin
          if (rd_pend_r) begin
            mask_r     <= NB'(din);
            byte_cnt_r <= 8'd0;
            state_r    <= S_MEM_WR;
          end
        end
        S_MEM_WR: begin
          byte_cnt_r <= 8'd0;
          state_r    <= S_IDLE;
        end
        S_MEM_RD: begin
          byte_cnt_r <= 8'd0;
          state_r    <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          shift_r    <= mem_rd_data_r;
          byte_cnt_r <= 8'd0;
          state_r    <= S_ECHO;
        end
        S_ECHO: begin
          if (wr_en_s) begin
            shift_r <= MEM_WIDTH'({shift_r, 8'h00});
            if (byte_cnt_r == NB_LAST) begin
              byte_cnt_r <= 8'd0;
              len_r      <= len_r - 8'd1;
              if (len_r == 8'd1) begin
                state_r <= S_IDLE;
              end else begin
                addr_r  <= addr_inc_s;
                state_r <= S_MEM_RD;
              end
            end else begin
              byte_cnt_r <= byte_cnt_r + 8'd1;
            end
          end
        end
        default: begin
          byte_cnt_r <= 8'd0;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

  // Memory write port: byte-masked, suppressed by reset, contents never cleared.
  always_ff @(posedge clk) begin
    if (!rst && (state_r == S_MEM_WR)) begin
      for (int i = 0; i < NB; i++) begin
        if (mask_r[i]) begin
          mem[addr_r][8*i +: 8] <= data_r[8*i +: 8];
        end
      end
    end
  end

  // Memory read port: one-cycle latency, addressed during MEM_RD.
  always_ff @(posedge clk) begin
    if (state_r == S_MEM_RD) begin
      mem_rd_data_r <= mem[addr_r];
    end
  end

endmodule
